mem_bank_arbiter: RTL and testbench

MEM_BANK_ARBITER -- requirements
Module: mem_bank_arbiter

---
 rtl/mem_bank_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_bank_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bank_arbiter.sv
// Arbitrates one memory bank between NumNarrowReq round-robin narrow ports and one wide port.
// Optional wide-stall statistics counter enabled by defining LAGD_MEM_ARB_STATS_EN.
module mem_bank_arbiter #(
  parameter int unsigned NumNarrowReq      = 4,
  parameter int unsigned AddrWidth         = 12,
  parameter int unsigned DataWidth         = 32,
  parameter int unsigned WidePriorityWait  = 4,
  parameter int unsigned BankAccessLatency = 1
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [NumNarrowReq-1:0]                   narrow_req_i,
  input  logic [NumNarrowReq-1:0][AddrWidth-1:0]    narrow_addr_i,
  input  logic [NumNarrowReq-1:0]                   narrow_we_i,
  input  logic [NumNarrowReq-1:0][DataWidth-1:0]    narrow_wdata_i,
  input  logic [NumNarrowReq-1:0][DataWidth/8-1:0]  narrow_be_i,
  output logic [NumNarrowReq-1:0]                   narrow_gnt_o,
  output logic [NumNarrowReq-1:0]                   narrow_rvalid_o,
  output logic [DataWidth-1:0]                      narrow_rdata_o,
  input  logic                                      wide_req_i,
  input  logic                                      wide_we_i,
  input  logic [AddrWidth-1:0]                      wide_addr_i,
  input  logic [DataWidth-1:0]                      wide_wdata_i,
  input  logic [DataWidth/8-1:0]                    wide_be_i,
  output logic                                      wide_gnt_o,
  output logic                                      wide_rvalid_o,
  output logic [DataWidth-1:0]                      wide_rdata_o,
  output logic                                      bank_req_o,
  output logic                                      bank_we_o,
  output logic [AddrWidth-1:0]                      bank_addr_o,
  output logic [DataWidth-1:0]                      bank_wdata_o,
  output logic [DataWidth/8-1:0]                    bank_be_o,
  input  logic [DataWidth-1:0]                      bank_rdata_i,
  output logic [31:0]                               stall_cnt_o
);

  localparam int unsigned IdxWidth    = (NumNarrowReq > 1) ? $clog2(NumNarrowReq) : 1;
  localparam int unsigned CandWidth   = IdxWidth + 1;
  localparam int unsigned StarveWidth = (WidePriorityWait > 0) ? $clog2(WidePriorityWait + 1) : 1;
  localparam int unsigned Lat         = BankAccessLatency;

  logic [IdxWidth-1:0]              ptr_q, ptr_d;
  logic [StarveWidth-1:0]           starve_q, starve_d;
  logic [Lat-1:0]                   pipe_valid_q, pipe_valid_d;
  logic [Lat-1:0]                   pipe_wide_q, pipe_wide_d;
  logic [Lat-1:0][IdxWidth-1:0]     pipe_idx_q, pipe_idx_d;

  logic                             narrow_win;
  logic [IdxWidth-1:0]              win_idx;
  logic [CandWidth-1:0]             cand;
  logic                             wide_first;

  // Search starts at the pointer and wraps, so the first requester found is the round-robin winner.
  always_comb begin
    narrow_win = 1'b0;
    win_idx    = '0;
    cand       = '0;
    for (int unsigned i = 0; i < NumNarrowReq; i++) begin
      cand = {1'b0, ptr_q} + CandWidth'(i);
      if (cand >= CandWidth'(NumNarrowReq)) begin
        cand = cand - CandWidth'(NumNarrowReq);
      end
      if (!narrow_win && narrow_req_i[cand[IdxWidth-1:0]]) begin
        narrow_win = 1'b1;
        win_idx    = cand[IdxWidth-1:0];
      end
    end
  end

  assign wide_first = (WidePriorityWait != 0) && (starve_q == StarveWidth'(WidePriorityWait));

  always_comb begin
    narrow_gnt_o = '0;
    wide_gnt_o   = 1'b0;
    if (!rst_i) begin
      if (wide_req_i && (wide_first || !narrow_win)) begin
        wide_gnt_o = 1'b1;
      end else if (narrow_win) begin
        narrow_gnt_o[win_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    bank_req_o   = wide_gnt_o | (|narrow_gnt_o);
    bank_we_o    = 1'b0;
    bank_addr_o  = '0;
    bank_wdata_o = '0;
    bank_be_o    = '0;
    if (wide_gnt_o) begin
      bank_we_o    = wide_we_i;
      bank_addr_o  = wide_addr_i;
      bank_wdata_o = wide_wdata_i;
      bank_be_o    = wide_be_i;
    end else if (|narrow_gnt_o) begin
      bank_we_o    = narrow_we_i[win_idx];
      bank_addr_o  = narrow_addr_i[win_idx];
      bank_wdata_o = narrow_wdata_i[win_idx];
      bank_be_o    = narrow_be_i[win_idx];
    end
  end

  // Pointer only advances on narrow grants; starvation count saturates so wide keeps priority until served.
  always_comb begin
    ptr_d    = ptr_q;
    starve_d = starve_q;
    if (|narrow_gnt_o) begin
      ptr_d = (win_idx == IdxWidth'(NumNarrowReq - 1)) ? '0 : win_idx + IdxWidth'(1);
    end
    if (!wide_req_i || wide_gnt_o) begin
      starve_d = '0;
    end else if ((WidePriorityWait != 0) && !wide_first) begin
      starve_d = starve_q + StarveWidth'(1);
    end
    pipe_valid_d[0] = bank_req_o;
    pipe_wide_d[0]  = wide_gnt_o;
    pipe_idx_d[0]   = win_idx;
    for (int unsigned s = 1; s < Lat; s++) begin
      pipe_valid_d[s] = pipe_valid_q[s-1];
      pipe_wide_d[s]  = pipe_wide_q[s-1];
      pipe_idx_d[s]   = pipe_idx_q[s-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q        <= '0;
      starve_q     <= '0;
      pipe_valid_q <= '0;
      pipe_wide_q  <= '0;
      pipe_idx_q   <= '0;
    end else begin
      ptr_q        <= ptr_d;
      starve_q     <= starve_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_wide_q  <= pipe_wide_d;
      pipe_idx_q   <= pipe_idx_d;
    end
  end

  always_comb begin
    narrow_rvalid_o = '0;
    wide_rvalid_o   = 1'b0;
    if (!rst_i && pipe_valid_q[Lat-1]) begin
      if (pipe_wide_q[Lat-1]) begin
        wide_rvalid_o = 1'b1;
      end else begin
        narrow_rvalid_o[pipe_idx_q[Lat-1]] = 1'b1;
      end
    end
  end

  assign narrow_rdata_o = bank_rdata_i;
  assign wide_rdata_o   = bank_rdata_i;

`ifdef LAGD_MEM_ARB_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (wide_req_i && !wide_gnt_o) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mem_bank_arbiter.sv
// Bench for mem_bank_arbiter: three configurations share one stimulus stream and are
// checked against a per-cycle grant model plus a response scoreboard queue.
module tb_mem_bank_arbiter;

  localparam int NumInst = 3;
  localparam int WaitCfg [NumInst] = '{4, 0, 2};
  localparam int LatCfg  [NumInst] = '{1, 3, 2};
`ifdef LAGD_MEM_ARB_STATS_EN
  localparam logic [31:0] StallExp = 32'd4;
`else
  localparam logic [31:0] StallExp = 32'd0;
`endif

  typedef struct {
    int inst;
    int due;
    bit is_wide;
    int idx;
  } resp_t;

  logic clk;
  logic rst;
  logic [3:0]        narrow_req;
  logic [3:0][11:0]  narrow_addr;
  logic [3:0]        narrow_we;
  logic [3:0][31:0]  narrow_wdata;
  logic [3:0][3:0]   narrow_be;
  logic              wide_req;
  logic              wide_we;
  logic [11:0]       wide_addr;
  logic [31:0]       wide_wdata;
  logic [3:0]        wide_be;
  logic [31:0]       bank_rdata;

  logic [NumInst-1:0][3:0]  narrow_gnt, narrow_rvalid, bank_be;
  logic [NumInst-1:0][31:0] narrow_rdata, wide_rdata, bank_wdata, stall_cnt;
  logic [NumInst-1:0][11:0] bank_addr;
  logic [NumInst-1:0]       wide_gnt, wide_rvalid, bank_req, bank_we;

  int          cyc;
  int          check_cnt;
  int          err_cnt;
  int          ptr_m    [NumInst];
  int          starve_m [NumInst];
  logic [31:0] stall_m  [NumInst];
  resp_t       resp_q   [$];

  mem_bank_arbiter #(.NumNarrowReq(4), .AddrWidth(12), .DataWidth(32),
                     .WidePriorityWait(4), .BankAccessLatency(1)) u_dut_a (
    .clk_i(clk), .rst_i(rst),
    .narrow_req_i(narrow_req), .narrow_addr_i(narrow_addr), .narrow_we_i(narrow_we),
    .narrow_wdata_i(narrow_wdata), .narrow_be_i(narrow_be),
    .narrow_gnt_o(narrow_gnt[0]), .narrow_rvalid_o(narrow_rvalid[0]), .narrow_rdata_o(narrow_rdata[0]),
    .wide_req_i(wide_req), .wide_we_i(wide_we), .wide_addr_i(wide_addr),
    .wide_wdata_i(wide_wdata), .wide_be_i(wide_be),
    .wide_gnt_o(wide_gnt[0]), .wide_rvalid_o(wide_rvalid[0]), .wide_rdata_o(wide_rdata[0]),
    .bank_req_o(bank_req[0]), .bank_we_o(bank_we[0]), .bank_addr_o(bank_addr[0]),
    .bank_wdata_o(bank_wdata[0]), .bank_be_o(bank_be[0]), .bank_rdata_i(bank_rdata),
    .stall_cnt_o(stall_cnt[0])
  );

  mem_bank_arbiter #(.NumNarrowReq(4), .AddrWidth(12), .DataWidth(32),
                     .WidePriorityWait(0), .BankAccessLatency(3)) u_dut_b (
    .clk_i(clk), .rst_i(rst),
    .narrow_req_i(narrow_req), .narrow_addr_i(narrow_addr), .narrow_we_i(narrow_we),
    .narrow_wdata_i(narrow_wdata), .narrow_be_i(narrow_be),
    .narrow_gnt_o(narrow_gnt[1]), .narrow_rvalid_o(narrow_rvalid[1]), .narrow_rdata_o(narrow_rdata[1]),
    .wide_req_i(wide_req), .wide_we_i(wide_we), .wide_addr_i(wide_addr),
    .wide_wdata_i(wide_wdata), .wide_be_i(wide_be),
    .wide_gnt_o(wide_gnt[1]), .wide_rvalid_o(wide_rvalid[1]), .wide_rdata_o(wide_rdata[1]),
    .bank_req_o(bank_req[1]), .bank_we_o(bank_we[1]), .bank_addr_o(bank_addr[1]),
    .bank_wdata_o(bank_wdata[1]), .bank_be_o(bank_be[1]), .bank_rdata_i(bank_rdata),
    .stall_cnt_o(stall_cnt[1])
  );

  mem_bank_arbiter #(.NumNarrowReq(4), .AddrWidth(12), .DataWidth(32),
                     .WidePriorityWait(2), .BankAccessLatency(2)) u_dut_c (
    .clk_i(clk), .rst_i(rst),
    .narrow_req_i(narrow_req), .narrow_addr_i(narrow_addr), .narrow_we_i(narrow_we),
    .narrow_wdata_i(narrow_wdata), .narrow_be_i(narrow_be),
    .narrow_gnt_o(narrow_gnt[2]), .narrow_rvalid_o(narrow_rvalid[2]), .narrow_rdata_o(narrow_rdata[2]),
    .wide_req_i(wide_req), .wide_we_i(wide_we), .wide_addr_i(wide_addr),
    .wide_wdata_i(wide_wdata), .wide_be_i(wide_be),
    .wide_gnt_o(wide_gnt[2]), .wide_rvalid_o(wide_rvalid[2]), .wide_rdata_o(wide_rdata[2]),
    .bank_req_o(bank_req[2]), .bank_we_o(bank_we[2]), .bank_addr_o(bank_addr[2]),
    .bank_wdata_o(bank_wdata[2]), .bank_be_o(bank_be[2]), .bank_rdata_i(bank_rdata),
    .stall_cnt_o(stall_cnt[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s (cycle %0d): observed 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] nreq, input logic wreq, input logic rst_v);
    rst        = rst_v;
    narrow_req = nreq;
    wide_req   = wreq;
    for (int i = 0; i < 4; i++) begin
      narrow_addr[i]  = 12'(cyc * 4 + i);
      narrow_we[i]    = ((cyc + i) % 3) == 0;
      narrow_wdata[i] = 32'h1000_0000 * (i + 1) + 32'(cyc);
      narrow_be[i]    = 4'(cyc + i);
    end
    wide_addr  = 12'h800 + 12'(cyc);
    wide_we    = (cyc % 2) == 1;
    wide_wdata = 32'hABCD_0000 + 32'(cyc);
    wide_be    = 4'hF;
    bank_rdata = 32'hC0DE_0000 + 32'(cyc);
  endtask

  // Per-cycle expectation for every instance; responses are queued at grant time and retired when due.
  task automatic checkModel();
    for (int k = 0; k < NumInst; k++) begin
      logic [3:0] exp_gnt;
      logic [3:0] exp_rv;
      logic       exp_wg;
      logic       exp_wrv;
      logic       prio;
      int         win;
      exp_gnt = '0;
      exp_rv  = '0;
      exp_wg  = 1'b0;
      exp_wrv = 1'b0;
      win     = -1;
      for (int e = resp_q.size() - 1; e >= 0; e--) begin
        if (resp_q[e].inst == k && (resp_q[e].due == cyc || rst)) begin
          if (!rst && resp_q[e].is_wide) exp_wrv = 1'b1;
          else if (!rst) exp_rv[resp_q[e].idx] = 1'b1;
          resp_q.delete(e);
        end
      end
      if (!rst) begin
        prio = (WaitCfg[k] > 0) && (starve_m[k] == WaitCfg[k]);
        for (int j = 0; j < 4; j++) begin
          if (win < 0 && narrow_req[(ptr_m[k] + j) % 4]) win = (ptr_m[k] + j) % 4;
        end
        if (wide_req && (prio || win < 0)) exp_wg = 1'b1;
        else if (win >= 0) exp_gnt[win] = 1'b1;
      end
      checkOutput($sformatf("i%0d_narrow_gnt", k), narrow_gnt[k], exp_gnt);
      checkOutput($sformatf("i%0d_wide_gnt", k), wide_gnt[k], exp_wg);
      checkOutput($sformatf("i%0d_bank_req", k), bank_req[k], exp_wg | (|exp_gnt));
      if (exp_wg) begin
        checkOutput($sformatf("i%0d_bank_addr_w", k), bank_addr[k], wide_addr);
        checkOutput($sformatf("i%0d_bank_we_w", k), bank_we[k], wide_we);
        checkOutput($sformatf("i%0d_bank_wdata_w", k), bank_wdata[k], wide_wdata);
      end else if (win >= 0 && !rst) begin
        checkOutput($sformatf("i%0d_bank_addr_n", k), bank_addr[k], narrow_addr[win]);
        checkOutput($sformatf("i%0d_bank_we_n", k), bank_we[k], narrow_we[win]);
        checkOutput($sformatf("i%0d_bank_wdata_n", k), bank_wdata[k], narrow_wdata[win]);
        checkOutput($sformatf("i%0d_bank_be_n", k), bank_be[k], narrow_be[win]);
      end
      checkOutput($sformatf("i%0d_narrow_rvalid", k), narrow_rvalid[k], exp_rv);
      checkOutput($sformatf("i%0d_wide_rvalid", k), wide_rvalid[k], exp_wrv);
      if (exp_wrv) checkOutput($sformatf("i%0d_wide_rdata", k), wide_rdata[k], bank_rdata);
      if (|exp_rv) checkOutput($sformatf("i%0d_narrow_rdata", k), narrow_rdata[k], bank_rdata);
      checkOutput($sformatf("i%0d_stall_cnt", k), stall_cnt[k], stall_m[k]);
      if (rst) begin
        ptr_m[k]    = 0;
        starve_m[k] = 0;
        stall_m[k]  = '0;
      end else begin
        if (exp_wg) resp_q.push_back('{k, cyc + LatCfg[k], 1'b1, 0});
        if (|exp_gnt) begin
          resp_q.push_back('{k, cyc + LatCfg[k], 1'b0, win});
          ptr_m[k] = (win + 1) % 4;
        end
        if (!wide_req || exp_wg) starve_m[k] = 0;
        else if (starve_m[k] < WaitCfg[k]) starve_m[k]++;
`ifdef LAGD_MEM_ARB_STATS_EN
        if (wide_req && !exp_wg) stall_m[k] = stall_m[k] + 32'd1;
`endif
      end
    end
  endtask

  task automatic evalCycle();
    #3;
    checkModel();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step(input logic [3:0] nreq, input logic wreq, input logic rst_v);
    applyStimulus(nreq, wreq, rst_v);
    evalCycle();
    tick();
  endtask

  initial begin
    logic [3:0] post_rst_seq [4];
    post_rst_seq = '{4'b0001, 4'b0010, 4'b0000, 4'b0100};
    cyc       = 0;
    check_cnt = 0;
    err_cnt   = 0;
    for (int k = 0; k < NumInst; k++) begin
      ptr_m[k]    = 0;
      starve_m[k] = 0;
      stall_m[k]  = '0;
    end
    applyStimulus(4'b0000, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    repeat (2) step(4'b0000, 1'b0, 1'b1);

    // All four narrow ports requesting: strict rotation, responses one cycle later.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b1111, 1'b0, 1'b0);
      evalCycle();
      checkOutput("rr_seq", narrow_gnt[0], 4'b0001 << (i % 4));
      if (i > 0) checkOutput("rr_rvalid", narrow_rvalid[0], 4'b0001 << ((i - 1) % 4));
      tick();
    end
    repeat (4) step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b1);

    // Wide starves behind narrow 0 until the wait threshold is reached.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(4'b0001, 1'b1, 1'b0);
      evalCycle();
      checkOutput("starve_wide_gnt", wide_gnt[0], i == 4);
      checkOutput("starve_narrow_gnt", narrow_gnt[0], (i == 4) ? 4'b0000 : 4'b0001);
      if (i == 5) checkOutput("starve_stall_cnt", stall_cnt[0], StallExp);
      tick();
    end
    step(4'b0000, 1'b0, 1'b1);

    // Zero wait: wide never preempts, then wins the cycle narrow drops.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(4'b0001, 1'b1, 1'b0);
      evalCycle();
      checkOutput("nopreempt_wide_gnt", wide_gnt[1], 1'b0);
      tick();
    end
    applyStimulus(4'b0000, 1'b1, 1'b0);
    evalCycle();
    checkOutput("wide_after_drop", wide_gnt[1], 1'b1);
    tick();
    repeat (5) step(4'b0000, 1'b0, 1'b0);

    // Latency-3 instance: wide read then narrow 2 read on consecutive cycles.
    applyStimulus(4'b0000, 1'b1, 1'b0);
    wide_addr = 12'h010;
    wide_we   = 1'b0;
    evalCycle();
    checkOutput("lat3_bank_addr_w", bank_addr[1], 12'h010);
    tick();
    applyStimulus(4'b0100, 1'b0, 1'b0);
    narrow_addr[2] = 12'h011;
    narrow_we[2]   = 1'b0;
    evalCycle();
    checkOutput("lat3_bank_addr_n", bank_addr[1], 12'h011);
    tick();
    applyStimulus(4'b0000, 1'b0, 1'b0);
    evalCycle();
    checkOutput("lat3_early_rvalid", wide_rvalid[1], 1'b0);
    tick();
    applyStimulus(4'b0000, 1'b0, 1'b0);
    evalCycle();
    checkOutput("lat3_wide_rvalid", wide_rvalid[1], 1'b1);
    checkOutput("lat3_wide_rdata", wide_rdata[1], bank_rdata);
    tick();
    applyStimulus(4'b0000, 1'b0, 1'b0);
    evalCycle();
    checkOutput("lat3_narrow_rvalid", narrow_rvalid[1], 4'b0100);
    checkOutput("lat3_narrow_rdata", narrow_rdata[1], bank_rdata);
    tick();
    repeat (3) step(4'b0000, 1'b0, 1'b0);

    // Reset one cycle after a read grant must swallow the in-flight response.
    applyStimulus(4'b0010, 1'b0, 1'b0);
    narrow_we[1] = 1'b0;
    evalCycle();
    checkOutput("rst_first_gnt", narrow_gnt[2], 4'b0010);
    tick();
    applyStimulus(4'b0000, 1'b0, 1'b1);
    evalCycle();
    checkOutput("rst_rvalid_during", narrow_rvalid[2], 4'b0000);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0000, 1'b0, 1'b0);
      evalCycle();
      checkOutput("rst_rvalid_after", narrow_rvalid[2], 4'b0000);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b1111, 1'b1, 1'b0);
      evalCycle();
      checkOutput("rst_ptr_gnt", narrow_gnt[2], post_rst_seq[i]);
      checkOutput("rst_cnt_wide", wide_gnt[2], i == 2);
      tick();
    end
    repeat (4) step(4'b0000, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
